qspi_psram_responder: RTL
=========================

// Module: qspi_psram_responder
// PURPOSE
//  Device-side (responder) end of the quad-SPI PSRAM link driven by EF_PSRAM_CTRL_V2.
//  Decodes quad read (0xEB) and quad write (0x38) transactions arriving on sck/ce_n/d.
//  Serves them from an on-chip byte array, so layer weights and results live in fabric.
//  Used as the on-chip PSRAM stand-in for FC and conv blocks.
//  A backdoor port preloads weights and biases and reads results back.
// PARAMETERS
//  MEM_BYTES    1024    byte capacity; address taken modulo MEM_BYTES (power of 2)
//  ADDR_WIDTH   24      bus address width (6 address nibbles)
//  WAIT_CYCLES  8       dummy sck cycles between address and read data (0xEB only)
//  RD_CMD       8'hEB   quad read opcode
//  WR_CMD       8'h38   quad write opcode
// PORTS
//  clk         in   1           system clock; oversamples sck
//  rst_n       in   1           async active-low reset
//  sck         in   1           serial clock from controller
//  ce_n        in   1           chip enable, active low
//  din         in   4           bus nibble driven by controller
//  dout        out  4           read-data nibble to controller
//  douten      out  4           per-bit output enable (4'hF in read data phase)
//  busy        out  1           1 while ce_n low and FSM not IDLE
//  cmd_err     out  1           1-clk pulse: unsupported opcode received
//  bd_we       in   1           backdoor write strobe
//  bd_addr     in   ADDR_WIDTH  backdoor byte address (mod MEM_BYTES)
//  bd_wdata    in   8           backdoor write byte
//  bd_rdata    out  8           backdoor read byte, registered, 1-clk latency
// BEHAVIOUR
//  Reset (async): dout=0, douten=0, busy=0, cmd_err=0, bd_rdata=0, FSM=IDLE.
//   The memory array is not reset.
//  sck, ce_n and din pass through 2-flop synchronisers.
//   Legal when sck high/low each >= 3 clk periods.
//   Edges are detected on the synchronised sck.
//   Inputs are sampled on sck rise; outputs update on sck fall.
//  FSM: IDLE -> CMD -> ADDR -> (DUMMY -> RDATA | WDATA | IGNORE).
//  IDLE: on synced ce_n falling, enter CMD and clear counters.
//  CMD: 8 sck rises; opcode bit taken from din[0], MSB first.
//   RD_CMD -> ADDR; WR_CMD -> ADDR.
//   Any other opcode: pulse cmd_err and go to IGNORE.
//  ADDR: 6 sck rises, din[3:0] per rise, MSB nibble first, forming addr.
//   Read -> DUMMY. Write -> WDATA.
//  DUMMY: WAIT_CYCLES sck rises; douten stays 0.
//   On the fall after the last dummy rise: douten=4'hF, dout=mem[addr][7:4].
//   Then enter RDATA.
//  RDATA: each sck fall drives the next nibble, high nibble then low nibble.
//   Address increments after each low nibble and wraps MEM_BYTES-1 -> 0.
//   Continues until ce_n rises.
//  WDATA: nibbles assembled high then low.
//   mem[addr] is written on the low-nibble rise; addr then increments (same wrap).
//   A half-received byte is discarded.
//  IGNORE: douten=0, no memory access, hold until ce_n rises.
//  ce_n rising in any state:
//   within 1 clk of the synced edge, douten=0, dout=0, FSM=IDLE.
//   A transaction in progress is aborted.
//  Backdoor is legal at any time.
//   Same-cycle write by the bus and bd_we: the bus write wins; bd write to that byte is dropped.
//   bd_rdata = mem[bd_addr] registered every clk (read-before-write).
//  rst_n low mid-transaction: outputs return to reset values immediately.
//   The next transaction needs a fresh ce_n falling edge.
// TESTING
//  1. bd write 0x010=0xA5, 0x011=0x3C; EB read @0x000010, 2 bytes.
//     -> dout nibbles A,5,3,C on successive rises after 8 dummies; douten=F only in data.
//  2. 0x38 write @0x000020 data 0x12,0x34; bd read 0x20, 0x21 -> 0x12, 0x34; cmd_err stays 0.
//  3. Wrap: mem[0x3FF]=0x77, mem[0x000]=0x88; EB read @0x0003FF, 2 bytes -> 0x77 then 0x88.
//  4. Abort: 0x38 @0x030 (mem=0x5A), send nibble 0xF, raise ce_n.
//     -> mem[0x030]=0x5A; douten=0, busy=0 within 4 clk.
//  5. Opcode 0x9F -> one cmd_err pulse, douten=0 until ce_n high; a following EB read returns correct data.
//  6. rst_n low during RDATA -> dout=0, douten=0 at once; memory preserved; next EB read correct.

Source files
------------

// File: rtl/qspi_psram_responder.sv
// -----------------------------------------------------------------------------
// qspi_psram_responder
//
// Device-side end of a quad-SPI PSRAM link. It decodes quad read (RD_CMD) and
// quad write (WR_CMD) transactions arriving on sck/ce_n/din and serves them from
// an on-chip byte array. A backdoor port preloads the array and reads results
// back without going through the serial link.
//
// The serial inputs are oversampled by clk through 2-flop synchronisers.
// Inputs are sampled on synchronised sck rises, and read data is launched on
// synchronised sck falls. Each sck phase must last at least 3 clk periods.
//
// Ports
//   clk       in   system clock, oversamples sck
//   rst_n     in   asynchronous active-low reset
//   sck       in   serial clock from the controller
//   ce_n      in   chip enable, active low
//   din       in   bus nibble driven by the controller
//   dout      out  read-data nibble to the controller
//   douten    out  per-bit output enable, 4'hF only while read data is driven
//   busy      out  high while ce_n is low and a transaction is being decoded
//   cmd_err   out  one-clk pulse when an unsupported opcode is received
//   bd_we     in   backdoor write strobe
//   bd_addr   in   backdoor byte address, taken modulo MEM_BYTES
//   bd_wdata  in   backdoor write byte
//   bd_rdata  out  backdoor read byte, registered, one-clk latency
// -----------------------------------------------------------------------------
module qspi_psram_responder #(
  parameter int unsigned MEM_BYTES   = 1024,
  parameter int unsigned ADDR_WIDTH  = 24,
  parameter int unsigned WAIT_CYCLES = 8,
  parameter logic [7:0]  RD_CMD      = 8'hEB,
  parameter logic [7:0]  WR_CMD      = 8'h38
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sck,
  input  logic                  ce_n,
  input  logic [3:0]            din,
  output logic [3:0]            dout,
  output logic [3:0]            douten,
  output logic                  busy,
  output logic                  cmd_err,
  input  logic                  bd_we,
  input  logic [ADDR_WIDTH-1:0] bd_addr,
  input  logic [7:0]            bd_wdata,
  output logic [7:0]            bd_rdata
);

  localparam int unsigned IDX_W     = $clog2(MEM_BYTES);
  localparam int unsigned ADDR_NIBS = ADDR_WIDTH / 4;
  localparam int unsigned CNT_W     = 8;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(7);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_NIBS - 1);
  localparam logic [CNT_W-1:0] DUMMY_N   = CNT_W'(WAIT_CYCLES);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_RDATA,
    ST_WDATA,
    ST_IGNORE
  } state_e;

  // Synchronisers and edge-detect history
  logic       sck_meta_q, sck_sync_q, sck_prev_q;
  logic       ce_meta_q, ce_sync_q, ce_prev_q;
  logic [3:0] din_meta_q, din_sync_q;

  // Transaction state
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [6:0]             op_q, op_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   is_rd_q, is_rd_d;
  logic                   lo_q, lo_d;       // next nibble is the low half
  logic [3:0]             whi_q, whi_d;     // held high nibble of a write byte
  logic [3:0]             dout_q, dout_d;
  logic [3:0]             douten_q, douten_d;
  logic                   cmd_err_q, cmd_err_d;
  logic [7:0]             bd_rdata_q;

  // Memory
  logic [7:0]             mem_q [MEM_BYTES];
  logic [IDX_W-1:0]       mem_idx;
  logic [IDX_W-1:0]       bd_idx;
  logic [7:0]             mem_rd;
  logic                   bus_we;
  logic [7:0]             bus_wdata;

  logic sck_rise, sck_fall, ce_fall;
  logic [7:0] opcode;

  // The ce_n synchroniser resets to "asserted" so that a controller still
  // holding ce_n low across a reset cannot fake a falling edge; a genuine new
  // transaction must first be seen with ce_n high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_meta_q <= 1'b0;
      sck_sync_q <= 1'b0;
      sck_prev_q <= 1'b0;
      ce_meta_q  <= 1'b0;
      ce_sync_q  <= 1'b0;
      ce_prev_q  <= 1'b0;
      din_meta_q <= 4'h0;
      din_sync_q <= 4'h0;
    end else begin
      sck_meta_q <= sck;
      sck_sync_q <= sck_meta_q;
      sck_prev_q <= sck_sync_q;
      ce_meta_q  <= ce_n;
      ce_sync_q  <= ce_meta_q;
      ce_prev_q  <= ce_sync_q;
      din_meta_q <= din;
      din_sync_q <= din_meta_q;
    end
  end

  assign sck_rise = sck_sync_q & ~sck_prev_q;
  assign sck_fall = ~sck_sync_q & sck_prev_q;
  assign ce_fall  = ce_prev_q & ~ce_sync_q;

  assign mem_idx   = addr_q[IDX_W-1:0];
  assign bd_idx    = bd_addr[IDX_W-1:0];
  assign mem_rd    = mem_q[mem_idx];
  assign opcode    = {op_q, din_sync_q[0]};
  assign bus_wdata = {whi_q, din_sync_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    addr_d    = addr_q;
    is_rd_d   = is_rd_q;
    lo_d      = lo_q;
    whi_d     = whi_q;
    dout_d    = dout_q;
    douten_d  = douten_q;
    cmd_err_d = 1'b0;
    bus_we    = 1'b0;

    if (state_q != ST_IDLE && ce_sync_q) begin
      // ce_n deasserted: abort whatever was in flight and release the bus.
      state_d  = ST_IDLE;
      dout_d   = 4'h0;
      douten_d = 4'h0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ce_fall) begin
            state_d  = ST_CMD;
            cnt_d    = '0;
            op_d     = '0;
            lo_d     = 1'b0;
            dout_d   = 4'h0;
            douten_d = 4'h0;
          end
        end

        ST_CMD: begin
          if (sck_rise) begin
            op_d  = {op_q[5:0], din_sync_q[0]};
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CMD_LAST) begin
              cnt_d = '0;
              if (opcode == RD_CMD) begin
                is_rd_d = 1'b1;
                state_d = ST_ADDR;
              end else if (opcode == WR_CMD) begin
                is_rd_d = 1'b0;
                state_d = ST_ADDR;
              end else begin
                cmd_err_d = 1'b1;
                state_d   = ST_IGNORE;
              end
            end
          end
        end

        ST_ADDR: begin
          if (sck_rise) begin
            addr_d = {addr_q[ADDR_WIDTH-5:0], din_sync_q};
            cnt_d  = cnt_q + CNT_ONE;
            if (cnt_q == ADDR_LAST) begin
              cnt_d   = '0;
              lo_d    = 1'b0;
              state_d = is_rd_q ? ST_DUMMY : ST_WDATA;
            end
          end
        end

        ST_DUMMY: begin
          // Count dummy rises; the first data nibble goes out on the fall that
          // follows the last one, so the controller sees it on the next rise.
          if (cnt_q == DUMMY_N) begin
            if (sck_fall) begin
              douten_d = 4'hF;
              dout_d   = mem_rd[7:4];
              lo_d     = 1'b1;
              state_d  = ST_RDATA;
            end
          end else if (sck_rise) begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        ST_RDATA: begin
          if (sck_fall) begin
            if (lo_q) begin
              dout_d                = mem_rd[3:0];
              addr_d[IDX_W-1:0]     = mem_idx + IDX_ONE;
              lo_d                  = 1'b0;
            end else begin
              dout_d = mem_rd[7:4];
              lo_d   = 1'b1;
            end
          end
        end

        ST_WDATA: begin
          if (sck_rise) begin
            if (lo_q) begin
              bus_we            = 1'b1;
              addr_d[IDX_W-1:0] = mem_idx + IDX_ONE;
              lo_d              = 1'b0;
            end else begin
              whi_d = din_sync_q;
              lo_d  = 1'b1;
            end
          end
        end

        ST_IGNORE: begin
          douten_d = 4'h0;
        end

        default: begin
          state_d  = ST_IDLE;
          douten_d = 4'h0;
          dout_d   = 4'h0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      addr_q    <= '0;
      is_rd_q   <= 1'b0;
      lo_q      <= 1'b0;
      whi_q     <= 4'h0;
      dout_q    <= 4'h0;
      douten_q  <= 4'h0;
      cmd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      is_rd_q   <= is_rd_d;
      lo_q      <= lo_d;
      whi_q     <= whi_d;
      dout_q    <= dout_d;
      douten_q  <= douten_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  // The array is deliberately not reset so contents survive rst_n. A bus
  // write and a backdoor write to the same byte in one cycle resolve to the
  // bus data.
  always_ff @(posedge clk) begin
    if (bd_we && !(bus_we && (bd_idx == mem_idx))) begin
      mem_q[bd_idx] <= bd_wdata;
    end
    if (bus_we) begin
      mem_q[mem_idx] <= bus_wdata;
    end
  end

  // Backdoor read returns the byte as it was before any write in this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bd_rdata_q <= 8'h00;
    end else begin
      bd_rdata_q <= mem_q[bd_idx];
    end
  end

  assign dout     = dout_q;
  assign douten   = douten_q;
  assign cmd_err  = cmd_err_q;
  assign bd_rdata = bd_rdata_q;
  assign busy     = (state_q != ST_IDLE) && !ce_sync_q;

  // Address bits above the array size only alias; the top nibble of the
  // shift register is shifted out unused.
  logic unused_bits;
  assign unused_bits = ^{addr_q[ADDR_WIDTH-1 -: 4], bd_addr[ADDR_WIDTH-1:IDX_W]};

endmodule
